rtype_sequencer: RTL and testbench
==================================

Name: rtype_sequencer

Overview:
- Multi-cycle controller that sequences the register-file/ALU datapath for RV32I R-type instructions.
- Accepts one 32-bit instruction per valid/ready handshake and decodes it into register numbers and the 4-bit ALU control code.
- Steps the datapath through DECODE, EXECUTE and WRITEBACK, pulsing regwrite for exactly one cycle.
- Sits between the instruction source (fetch unit or testbench) and the datapath. Reports completion, illegal instructions, the captured zero flag and a retired-instruction count.

Parameters:
- CNT_WIDTH, 16, width of the retired-instruction counter (wraps modulo 2^CNT_WIDTH).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- instr  input  32  instruction word; sampled only on handshake.
- instr_valid  input  1  source has an instruction on instr.
- instr_ready  output  1  sequencer can accept an instruction.
- zero_flag  input  1  ALU zero flag from the datapath.
- read_reg_num1  output  5  rs1 field to the datapath.
- read_reg_num2  output  5  rs2 field to the datapath.
- write_reg  output  5  rd field to the datapath.
- alu_control  output  4  ALU operation code.
- regwrite  output  1  register-file write enable.
- done  output  1  one-cycle pulse, instruction retired.
- illegal  output  1  one-cycle pulse, instruction rejected.
- zero_last  output  1  zero_flag captured at the last retirement.
- retired_count  output  CNT_WIDTH  number of retired instructions.

Behaviour:
- Reset: asserting reset (low) forces IDLE immediately, regardless of clock. All outputs read 0 while reset is low, except instr_ready, which is 0 during reset and 1 in the first IDLE cycle after release.
- Reset mid-operation aborts the instruction; no regwrite pulse is issued.
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
- instr_ready = 1 only in IDLE. Handshake = instr_valid & instr_ready at a rising edge; instr is latched into an internal register and the state becomes DECODE.
- IDLE with instr_valid = 0: stay in IDLE. instr is ignored in all other states.
- DECODE: the latched fields drive the datapath outputs. read_reg_num1 = [19:15], read_reg_num2 = [24:20], write_reg = [11:7]. These values hold until the next handshake.
- Legality: an instruction is legal when opcode [6:0] = 7'b0110011 and {funct7, funct3} is one of the table entries below.
  - AND 0000000/111 -> 0000
  - OR 0000000/110 -> 0001
  - ADD 0000000/000 -> 0010
  - XOR 0000000/100 -> 0011
  - SLL 0000000/001 -> 0100
  - SRL 0000000/101 -> 0101
  - SUB 0100000/000 -> 0110
  - SLT 0000000/010 -> 0111
  - SRA 0100000/101 -> 1000
  - SLTU 0000000/011 -> 1001
- Illegal instruction: illegal = 1 for the DECODE cycle, then next state is IDLE. regwrite, done and retired_count are unaffected, and alu_control keeps its previous value.
- Legal instruction: alu_control takes the new code in DECODE, then DECODE -> EXECUTE -> WRITEBACK.
- EXECUTE: all outputs held; regwrite = 0. This gives the ALU a full settling cycle.
- WRITEBACK:
  - regwrite = 1 for this single cycle, except when rd = 0, where regwrite stays 0 (x0 is protected).
  - done = 1 in this cycle.
  - At the closing edge, zero_last <= zero_flag and retired_count increments.
  - Next state is IDLE.
- Latency: handshake edge E0; DECODE is the cycle after E0, EXECUTE after E1, WRITEBACK after E2. Register write occurs at edge E3 and instr_ready = 1 again after E3. Legal throughput is one instruction per 4 cycles; illegal occupancy is 2 cycles.
- retired_count wraps from 2^CNT_WIDTH-1 to 0 with no flag. It counts rd = 0 retirements.
- done and illegal are never asserted together. regwrite is never 1 outside WRITEBACK.

Test Plan:
- Reset/idle: hold reset low for 3 cycles, then release -> all outputs 0 during reset, instr_ready = 1 first cycle after release, no state change while instr_valid = 0.
- ADD: instr 32'h003100B3 (add x1,x2,x3) with valid at E0 -> read_reg_num1 = 2, read_reg_num2 = 3, write_reg = 1, alu_control = 0010 from DECODE. regwrite = 1 and done = 1 only in the cycle after E2; retired_count = 1; instr_ready back at E3.
- SUB with zero: x5 = x6 = 7, instr 32'h406302B3 (sub x5,x6,x6) -> alu_control = 0110, zero_last = 1 after retirement; following or x7,x6,x6 -> zero_last = 0.
- Illegal/rd0: instr 32'h00000013 (addi) -> illegal pulse 1 cycle, no regwrite or done, count unchanged. instr 32'h00310033 (add x0) -> done = 1, regwrite stays 0, count increments.
- Back-to-back and wrap: instr_valid held high with 5 legal instructions, CNT_WIDTH = 2 -> one accept per 4 cycles, retired_count sequence 1,2,3,0,1.
- Async abort: drop reset in the EXECUTE cycle between clock edges -> outputs clear immediately, no regwrite; after release the next instruction completes normally.

Source files
------------

// File: rtl/rtype_sequencer.sv
// Multi-cycle sequencer for RV32I R-type instructions: accepts one instruction per
// handshake and steps the register-file/ALU datapath through DECODE, EXECUTE, WRITEBACK.
module rtype_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 zero_flag,
    output logic [4:0]           read_reg_num1,
    output logic [4:0]           read_reg_num2,
    output logic [4:0]           write_reg,
    output logic [3:0]           alu_control,
    output logic                 regwrite,
    output logic                 done,
    output logic                 illegal,
    output logic                 zero_last,
    output logic [CNT_WIDTH-1:0] retired_count
);

    typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_instr;
    logic [3:0]            r_alu;
    logic                  r_zero;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_legal;
    logic [3:0]            w_code;
    logic                  w_hs;

    assign read_reg_num1 = r_instr[19:15];
    assign read_reg_num2 = r_instr[24:20];
    assign write_reg     = r_instr[11:7];
    assign zero_last     = r_zero;
    assign retired_count = r_cnt;
    assign w_hs          = instr_valid & instr_ready;

    // Decode of the latched word; only consulted while in DECODE.
    always_comb begin
        w_legal = 1'b0;
        w_code  = 4'b0000;
        if (r_instr[6:0] == 7'b0110011) begin
            w_legal = 1'b1;
            case ({r_instr[31:25], r_instr[14:12]})
                10'b0000000_111: w_code = 4'b0000;
                10'b0000000_110: w_code = 4'b0001;
                10'b0000000_000: w_code = 4'b0010;
                10'b0000000_100: w_code = 4'b0011;
                10'b0000000_001: w_code = 4'b0100;
                10'b0000000_101: w_code = 4'b0101;
                10'b0100000_000: w_code = 4'b0110;
                10'b0000000_010: w_code = 4'b0111;
                10'b0100000_101: w_code = 4'b1000;
                10'b0000000_011: w_code = 4'b1001;
                default:         w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        regwrite    = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        alu_control = r_alu;
        case (r_state)
            IDLE: begin
                // Gated by reset so the source never sees ready while held in reset.
                instr_ready = reset;
                if (instr_valid) w_next = DECODE;
            end
            DECODE: begin
                if (w_legal) begin
                    alu_control = w_code;
                    w_next      = EXECUTE;
                end else begin
                    illegal = 1'b1;
                    w_next  = IDLE;
                end
            end
            EXECUTE: w_next = WRITEBACK;
            WRITEBACK: begin
                regwrite = (r_instr[11:7] != 5'd0);
                done     = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_instr <= '0;
            r_alu   <= '0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) r_instr <= instr;
            if (r_state == DECODE && w_legal) r_alu <= w_code;
            if (r_state == WRITEBACK) begin
                r_zero <= zero_flag;
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Scoreboard bench for rtype_sequencer: a small register file/ALU model closes the
// datapath loop and expected results are queued at each accepted handshake.
module tb_rtype_sequencer;

    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          zero_flag;
    logic [4:0]    read_reg_num1, read_reg_num2, write_reg;
    logic [3:0]    alu_control;
    logic          regwrite, done, illegal, zero_last;
    logic [CW-1:0] retired_count;

    rtype_sequencer #(.CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .zero_flag(zero_flag),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
        .done(done), .illegal(illegal), .zero_last(zero_last),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return a << b[4:0];
            4'd5: return a >> b[4:0];
            4'd6: return a - b;
            4'd7: return {31'b0, $signed(a) < $signed(b)};
            4'd8: return 32'($signed(a) >>> b[4:0]);
            4'd9: return {31'b0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    // {legal, code}
    function automatic logic [4:0] dec(input logic [31:0] w);
        if (w[6:0] != 7'b0110011) return 5'b0_0000;
        case ({w[31:25], w[14:12]})
            10'b0000000_111: return 5'b1_0000;
            10'b0000000_110: return 5'b1_0001;
            10'b0000000_000: return 5'b1_0010;
            10'b0000000_100: return 5'b1_0011;
            10'b0000000_001: return 5'b1_0100;
            10'b0000000_101: return 5'b1_0101;
            10'b0100000_000: return 5'b1_0110;
            10'b0000000_010: return 5'b1_0111;
            10'b0100000_101: return 5'b1_1000;
            10'b0000000_011: return 5'b1_1001;
            default:         return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] rinit(input int i);
        if (i == 0) return 32'd0;
        if (i == 6) return 32'd7;
        if (i == 3) return 32'hFFFF_FFF0;
        return 32'(i * 3 + 1);
    endfunction

    // Datapath model driven by the DUT's outputs.
    logic [31:0] dp_rf [32];
    logic [31:0] dp_res;
    assign dp_res    = alu(dp_rf[read_reg_num1], dp_rf[read_reg_num2], alu_control);
    assign zero_flag = (dp_res == 32'd0);

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) dp_rf[i] <= rinit(i);
        end else if (regwrite) begin
            dp_rf[write_reg] <= dp_res;
        end
    end

    typedef struct {
        logic [31:0] w;
        int          hs;
        logic        legal;
        logic [3:0]  code;
    } item_t;

    item_t       q[$];
    logic [31:0] ref_rf [32];
    logic [CW-1:0] exp_cnt;
    logic        exp_zero;
    logic [3:0]  exp_alu;
    bit          pend = 0;
    bit          b2b  = 0;
    int          ncnt = 0;

    wire [25:0] outs = {instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
                        regwrite, done, illegal, zero_last, retired_count};

    // Monitor/scoreboard, sampling on the falling edge.
    initial begin
        int    last_hs = 0;
        int    b2b_n   = 0;
        item_t it;
        logic [4:0]  d;
        logic [31:0] r;
        forever begin
            @(negedge clock);
            ncnt++;
            if (!reset) begin
                q.delete();
                exp_cnt = '0; exp_zero = 1'b0; exp_alu = 4'd0; pend = 0;
                for (int i = 0; i < 32; i++) ref_rf[i] = rinit(i);
            end else begin
                if (pend) begin
                    chk("cnt", 32'(retired_count), 32'(exp_cnt));
                    chk("zero_last", 32'(zero_last), 32'(exp_zero));
                    chk("rdy_after_wb", 32'(instr_ready), 32'd1);
                    pend = 0;
                end
                chk("done_ill_excl", 32'(done & illegal), 32'd0);
                chk("rw_outside_wb", 32'(regwrite & ~done), 32'd0);
                if (q.size() != 0 && q[0].legal && q[0].hs + 1 == ncnt) begin
                    chk("alu_decode", 32'(alu_control), 32'(q[0].code));
                    chk("rs1_decode", 32'(read_reg_num1), 32'(q[0].w[19:15]));
                end
                if (done || illegal) begin
                    chk("q_nonempty", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        it = q.pop_front();
                        chk("legal", 32'(done), 32'(it.legal));
                        if (illegal) begin
                            chk("lat_ill", 32'(ncnt - it.hs), 32'd1);
                            chk("alu_hold", 32'(alu_control), 32'(exp_alu));
                            chk("rw_ill", 32'(regwrite), 32'd0);
                        end else begin
                            chk("lat_done", 32'(ncnt - it.hs), 32'd3);
                            chk("rs1", 32'(read_reg_num1), 32'(it.w[19:15]));
                            chk("rs2", 32'(read_reg_num2), 32'(it.w[24:20]));
                            chk("rd", 32'(write_reg), 32'(it.w[11:7]));
                            chk("alu", 32'(alu_control), 32'(it.code));
                            chk("regwrite", 32'(regwrite), 32'(it.w[11:7] != 5'd0));
                            r = alu(ref_rf[it.w[19:15]], ref_rf[it.w[24:20]], it.code);
                            if (it.w[11:7] != 5'd0) ref_rf[it.w[11:7]] = r;
                            exp_zero = (r == 32'd0);
                            exp_alu  = it.code;
                            exp_cnt  = exp_cnt + 1'b1;
                            pend     = 1;
                        end
                    end
                end
                if (instr_valid && instr_ready) begin
                    d = dec(instr);
                    q.push_back('{w: instr, hs: ncnt, legal: d[4], code: d[3:0]});
                    if (b2b) begin
                        if (b2b_n > 0) chk("b2b_spacing", 32'(ncnt - last_hs), 32'd4);
                        b2b_n++;
                    end
                    last_hs = ncnt;
                end
            end
        end
    end

    // Called at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [31:0] w, input bit keep);
        int n = 0;
        instr = w;
        instr_valid = 1'b1;
        @(negedge clock);
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("hs_wait", 32'(instr_ready), 32'd1);
        @(posedge clock);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!(instr_ready && q.size() == 0 && !pend) && n < 30);
        chk("idle_wait", 32'(n < 30), 32'd1);
        chk("cnt_idle", 32'(retired_count), 32'(exp_cnt));
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; instr = '0; instr_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            #1 chk("rst_outs", 32'(outs), 32'd0);
        end
        #2 reset = 1'b1;
        #1 chk("rdy_release", 32'(instr_ready), 32'd1);
        repeat (3) begin
            @(negedge clock);
            #1 chk("idle_outs", 32'(outs), 32'h0200_0000);
        end
        @(posedge clock);
        #1;

        send(32'h003100B3, 0); wait_idle();
        send(32'h406302B3, 0); wait_idle();
        send(32'h006363B3, 0); wait_idle();
        send(32'h00000013, 0); wait_idle();
        send(enc(7'b0000001, 3'b000, 5'd1, 5'd2, 5'd3), 0); wait_idle();
        send(32'h00310033, 0); wait_idle();

        b2b = 1;
        send(enc(7'b0000000, 3'b100, 5'd11, 5'd2, 5'd4), 1);
        send(enc(7'b0000000, 3'b001, 5'd12, 5'd4, 5'd2), 1);
        send(enc(7'b0000000, 3'b101, 5'd13, 5'd3, 5'd2), 1);
        send(enc(7'b0100000, 3'b101, 5'd14, 5'd3, 5'd2), 1);
        send(enc(7'b0000000, 3'b011, 5'd15, 5'd2, 5'd3), 0);
        b2b = 0;
        wait_idle();
        send(enc(7'b0000000, 3'b111, 5'd16, 5'd3, 5'd6), 0); wait_idle();
        send(enc(7'b0000000, 3'b010, 5'd17, 5'd3, 5'd2), 0); wait_idle();

        // Abort in EXECUTE, between clock edges.
        send(enc(7'b0000000, 3'b000, 5'd9, 5'd2, 5'd3), 0);
        @(posedge clock);
        #3 reset = 1'b0;
        #1 chk("abort_outs", 32'(outs), 32'd0);
        chk("abort_rw", 32'(regwrite), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        send(enc(7'b0100000, 3'b000, 5'd10, 5'd6, 5'd6), 0); wait_idle();

        for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), dp_rf[i], ref_rf[i]);
        chk("q_drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
